pio_in_capture: RTL and testbench

- Input-side counterpart to the LED output PIO: HPS-readable Avalon-MM slave that samples WIDTH external push-buttons or switches.
- Per-bit datapath: synchronise, debounce, detect edges, latch edges into a write-1-to-clear capture register, raise a level interrupt.
- Sits in the FPGA fabric on clk_100, behind the HPS lightweight bridge.

---
 rtl/pio_in_pkg.sv | 16 +
 rtl/pio_in_debounce_bit.sv | 37 +++
 rtl/pio_in_capture.sv | 88 ++++++++
 tb/tb_pio_in_capture.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pio_in_pkg.sv
// Shared constants for the PIO input-capture block: register map and edge modes.
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_MODE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2,
    EDGE_NONE = 2'd3
  } edge_mode_e;

endpackage

// File: rtl/pio_in_debounce_bit.sv
// One input lane: 2-FF synchroniser, stability counter and accepted-level flop.
module pio_in_debounce_bit #(
  parameter int   TIMEOUT       = 10000,
  parameter int   TIMEOUT_WIDTH = 32,
  parameter logic IDLE_LEVEL    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable
);

  logic                     sync_q1, sync_q2;
  logic [TIMEOUT_WIDTH-1:0] cnt;

  // Synchronise, then accept a new level only after TIMEOUT consecutive differing cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= IDLE_LEVEL;
      sync_q2 <= IDLE_LEVEL;
      stable  <= IDLE_LEVEL;
      cnt     <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (cnt == TIMEOUT_WIDTH'(TIMEOUT - 1)) begin
        stable <= sync_q2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pio_in_capture.sv
// Avalon-MM input PIO: debounced inputs, selectable edge capture (W1C), masked level irq.
module pio_in_capture
  import pio_in_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               TIMEOUT       = 10000,
  parameter int               TIMEOUT_WIDTH = 32,
  parameter logic [WIDTH-1:0] IDLE_LEVEL    = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] stable, stable_d;
  logic [WIDTH-1:0] rise, fall, edge_set, edge_clr;
  logic [WIDTH-1:0] edge_capture, irq_mask;
  edge_mode_e       edge_mode;
  logic [31:0]      rd_mux;

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_lane
      pio_in_debounce_bit #(
        .TIMEOUT      (TIMEOUT),
        .TIMEOUT_WIDTH(TIMEOUT_WIDTH),
        .IDLE_LEVEL   (IDLE_LEVEL[g])
      ) u_db (
        .clk   (clk),
        .reset (reset),
        .din   (data_in[g]),
        .stable(stable[g])
      );
    end
  endgenerate

  assign rise = stable & ~stable_d;
  assign fall = ~stable & stable_d;

  // Edge source selection and W1C clear vector.
  always_comb begin
    edge_set = '0;
    case (edge_mode)
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      EDGE_BOTH: edge_set = rise | fall;
      default:   edge_set = '0;
    endcase
    edge_clr = (write && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux[WIDTH-1:0] = stable;
      ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture;
      default:   rd_mux[1:0]       = edge_mode;
    endcase
  end

  // Register file, edge history, read data and irq; set beats clear on the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d     <= IDLE_LEVEL;
      edge_capture <= '0;
      irq_mask     <= '0;
      edge_mode    <= EDGE_RISE;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      stable_d     <= stable;
      edge_capture <= (edge_capture & ~edge_clr) | edge_set;
      irq          <= |(edge_capture & irq_mask);
      if (read) readdata <= rd_mux;
      if (write && address == ADDR_MASK) irq_mask  <= writedata[WIDTH-1:0];
      if (write && address == ADDR_MODE) edge_mode <= edge_mode_e'(writedata[1:0]);
    end
  end

endmodule

// File: tb/tb_pio_in_capture.sv
// Directed bench for pio_in_capture with TIMEOUT = 4, WIDTH = 4, IDLE_LEVEL = 4'hF.
module tb_pio_in_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  data_in;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int passed = 0;

  pio_in_capture #(
    .WIDTH(4), .TIMEOUT(4), .TIMEOUT_WIDTH(8), .IDLE_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a; read = 1'b1;
    tick();
    read = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = 4'hF; address = 0; read = 0; write = 0; writedata = 0;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (readdata !== 32'h0) $display("FAIL reset_readdata got %h exp %h", readdata, 32'h0); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", irq); else passed++;
    bus_read(2'd0);
    checks++; if (readdata !== 32'hF) $display("FAIL reset_data got %h exp %h", readdata, 32'hF); else passed++;
    bus_read(2'd1);
    checks++; if (readdata !== 32'h0) $display("FAIL reset_mask got %h exp %h", readdata, 32'h0); else passed++;
    bus_read(2'd2);
    checks++; if (readdata !== 32'h0) $display("FAIL reset_edge got %h exp %h", readdata, 32'h0); else passed++;
    bus_read(2'd3);
    checks++; if (readdata !== 32'h0) $display("FAIL reset_mode got %h exp %h", readdata, 32'h0); else passed++;
  endtask

  // stable flips on the 6th edge after the change; readdata shows it one edge later.
  task automatic test_debounce();
    logic [31:0] exp;
    data_in = 4'hE; address = 2'd0; read = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      exp = (j <= 6) ? 32'hF : 32'hE;
      checks++; if (readdata !== exp) $display("FAIL debounce_t%0d got %h exp %h", j, readdata, exp); else passed++;
    end
    data_in = 4'hC;
    repeat (3) tick();
    data_in = 4'hE;
    for (int j = 1; j <= 8; j++) begin
      tick();
      checks++; if (readdata !== 32'hE) $display("FAIL glitch_t%0d got %h exp %h", j, readdata, 32'hE); else passed++;
    end
    read = 1'b0;
  endtask

  task automatic test_edge_irq();
    logic exp_irq;
    bus_write(2'd3, 32'd3);
    data_in = 4'hF;
    repeat (10) tick();
    bus_write(2'd2, 32'hF);
    bus_write(2'd3, 32'd1);
    bus_write(2'd1, 32'h1);
    checks++; if (irq !== 1'b0) $display("FAIL irq_idle got %b exp 0", irq); else passed++;
    data_in = 4'hE;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp_irq = (j >= 8);
      checks++; if (irq !== exp_irq) $display("FAIL fall_irq_t%0d got %b exp %b", j, irq, exp_irq); else passed++;
    end
    bus_read(2'd2);
    checks++; if (readdata !== 32'h1) $display("FAIL fall_capture got %h exp %h", readdata, 32'h1); else passed++;
    bus_write(2'd2, 32'h1);
    checks++; if (irq !== 1'b1) $display("FAIL w1c_irq_lag got %b exp 1", irq); else passed++;
    tick();
    checks++; if (irq !== 1'b0) $display("FAIL w1c_irq got %b exp 0", irq); else passed++;
    bus_read(2'd2);
    checks++; if (readdata !== 32'h0) $display("FAIL w1c_capture got %h exp %h", readdata, 32'h0); else passed++;
  endtask

  task automatic test_both_edges();
    bus_write(2'd3, 32'd2);
    data_in = 4'hA;
    repeat (8) tick();
    data_in = 4'hE;
    repeat (8) tick();
    bus_read(2'd2);
    checks++; if (readdata !== 32'h4) $display("FAIL both_capture got %h exp %h", readdata, 32'h4); else passed++;
    checks++; if (irq !== 1'b0) $display("FAIL both_masked_irq got %b exp 0", irq); else passed++;
    bus_read(2'd0);
    checks++; if (readdata !== 32'hE) $display("FAIL both_data got %h exp %h", readdata, 32'hE); else passed++;
  endtask

  task automatic test_set_clear_collision();
    data_in = 4'hF;
    repeat (8) tick();
    bus_read(2'd2);
    checks++; if (readdata !== 32'h5) $display("FAIL rise_capture got %h exp %h", readdata, 32'h5); else passed++;
    data_in = 4'hE;
    repeat (6) tick();
    address = 2'd2; writedata = 32'h1; write = 1'b1;
    tick();
    write = 1'b0; writedata = '0;
    bus_read(2'd2);
    checks++; if (readdata !== 32'h5) $display("FAIL set_wins got %h exp %h", readdata, 32'h5); else passed++;
    bus_write(2'd2, 32'h1);
    bus_read(2'd2);
    checks++; if (readdata !== 32'h4) $display("FAIL plain_w1c got %h exp %h", readdata, 32'h4); else passed++;
  endtask

  task automatic test_rw_same_cycle();
    address = 2'd1; writedata = 32'h3; read = 1'b1; write = 1'b1;
    tick();
    read = 1'b0; write = 1'b0;
    checks++; if (readdata !== 32'h1) $display("FAIL rw_old_value got %h exp %h", readdata, 32'h1); else passed++;
    bus_read(2'd1);
    checks++; if (readdata !== 32'h3) $display("FAIL rw_new_mask got %h exp %h", readdata, 32'h3); else passed++;
    bus_write(2'd0, 32'h0);
    bus_read(2'd0);
    checks++; if (readdata !== 32'hE) $display("FAIL data_ro got %h exp %h", readdata, 32'hE); else passed++;
    address = 2'd2;
    repeat (2) tick();
    checks++; if (readdata !== 32'hE) $display("FAIL readdata_hold got %h exp %h", readdata, 32'hE); else passed++;
    bus_write(2'd1, 32'h4);
    checks++; if (irq !== 1'b0) $display("FAIL mask_irq_lag got %b exp 0", irq); else passed++;
    tick();
    checks++; if (irq !== 1'b1) $display("FAIL mask_irq got %b exp 1", irq); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    data_in = 4'h7;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    address = 2'd0; read = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      exp = (j <= 6) ? 32'hF : 32'h7;
      checks++; if (readdata !== exp) $display("FAIL rst_redeb_t%0d got %h exp %h", j, readdata, exp); else passed++;
      checks++; if (irq !== 1'b0) $display("FAIL rst_irq_t%0d got %b exp 0", j, irq); else passed++;
    end
    read = 1'b0;
    bus_read(2'd2);
    checks++; if (readdata !== 32'h0) $display("FAIL rst_capture got %h exp %h", readdata, 32'h0); else passed++;
    bus_read(2'd1);
    checks++; if (readdata !== 32'h0) $display("FAIL rst_mask got %h exp %h", readdata, 32'h0); else passed++;
  endtask

  initial begin
    reset = 1'b1; data_in = 4'hF; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
    @(negedge clk);
    test_reset();
    test_debounce();
    test_edge_irq();
    test_both_edges();
    test_set_clear_collision();
    test_rw_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
